// File: rtl/video_pkg.sv
// Shared types and helpers for the video input path: writer FSM states,
// Wishbone cycle-type codes and frame geometry.
package video_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DATA,
        BURST,
        IRQ
    } vfw_state_t;

    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_EOB  = 3'b111;

    // Four 8-bit pixels are packed into each 32-bit word.
    function automatic int frame_words(input int width, input int height);
        return (width * height) / 4;
    endfunction

endpackage

// File: rtl/vfw_addr_queue.sv
// Two-entry frame base address queue with fall-through when empty and a
// sticky overflow flag for addresses dropped while full.
module vfw_addr_queue (
    input  logic        clk,
    input  logic        nRST,
    input  logic        push,
    input  logic        pop,
    input  logic        irq_ack,
    input  logic [31:0] din,
    output logic [31:0] head,
    output logic        empty,
    output logic        ovf
);
    import video_pkg::*;

    logic [31:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        full;
    logic        bypass;
    logic        accept;
    logic        take;
    logic [31:0] raw_head;

    assign empty    = (count == 2'd0);
    assign full     = (count == 2'd2);
    assign raw_head = empty ? din : mem[rd_ptr];
    assign head     = raw_head & 32'hFFFF_FFFC;

    // An address pushed into an empty queue and popped in the same cycle is never stored.
    assign bypass = empty & push & pop;
    assign accept = push & (~full | pop) & ~bypass;
    assign take   = pop & ~empty;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            ovf    <= 1'b0;
        end else begin
            if (accept) wr_ptr <= ~wr_ptr;
            if (take)   rd_ptr <= ~rd_ptr;
            case ({accept, take})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            ovf <= (push & full & ~pop) | (ovf & ~irq_ack);
        end
    end

    // NOTE: storage needs no reset; count gates every read of an unwritten entry.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/video_frame_writer.sv
// Frame store master: drains the pixel FIFO into RAM one frame per queued
// base address, using Wishbone incrementing bursts with error abort.
module video_frame_writer #(
    parameter int P_WIDTH    = 640,
    parameter int P_HEIGHT   = 480,
    parameter int BURST_LEN  = 16,
    parameter int INT_CYCLES = 4,
    parameter int LVL_W      = 8
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             addr_wr,
    input  logic [31:0]      addr_in,
    input  logic             irq_ack,
    input  logic [LVL_W-1:0] fifo_level,
    input  logic [31:0]      fifo_data,
    output logic             fifo_rd,
    output logic             fifo_flush,
    output logic             irq,
    output logic [3:0]       status,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [3:0]       wb_sel_o,
    output logic [31:0]      wb_adr_o,
    output logic [31:0]      wb_dat_o,
    output logic [2:0]       wb_cti_o,
    output logic [1:0]       wb_bte_o,
    input  logic             wb_ack_i,
    input  logic             wb_err_i
);
    import video_pkg::*;

    localparam int WPF    = frame_words(P_WIDTH, P_HEIGHT);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int IRQ_W  = $clog2(INT_CYCLES);

    localparam logic [LVL_W:0]    LVL_BURST = (LVL_W+1)'(BURST_LEN);
    localparam logic [19:0]       LAST_WORD = 20'(WPF - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [IRQ_W-1:0]  LAST_IRQ  = IRQ_W'(INT_CYCLES - 1);

    generate
        if ((WPF % BURST_LEN) != 0 || BURST_LEN < 1 || BURST_LEN > 64 ||
            (BURST_LEN & (BURST_LEN - 1)) != 0 || INT_CYCLES < 3) begin : g_bad_params
            $error("video_frame_writer: illegal frame geometry or burst parameters");
        end
    endgenerate

    vfw_state_t        state, state_n;
    logic [31:0]       base;
    logic [19:0]       word_cnt;
    logic [BEAT_W-1:0] beat;
    logic [IRQ_W-1:0]  irq_cnt;
    logic              done_flag, err_flag;
    logic              set_done, set_err;
    logic              q_pop, q_empty, q_ovf;
    logic [31:0]       q_head;
    logic              last_beat;

    vfw_addr_queue u_addr_queue (
        .clk     (clk),
        .nRST    (nRST),
        .push    (addr_wr),
        .pop     (q_pop),
        .irq_ack (irq_ack),
        .din     (addr_in),
        .head    (q_head),
        .empty   (q_empty),
        .ovf     (q_ovf)
    );

    assign last_beat = (beat == LAST_BEAT);
    assign status    = {q_ovf, err_flag, done_flag, state != IDLE};
    assign wb_sel_o  = 4'hF;
    assign wb_bte_o  = 2'b00;

    // Bus outputs are decoded from state so an asynchronous reset clears them at once.
    always_comb begin
        state_n    = state;
        q_pop      = 1'b0;
        fifo_rd    = 1'b0;
        fifo_flush = 1'b0;
        set_done   = 1'b0;
        set_err    = 1'b0;
        irq        = 1'b0;
        wb_cyc_o   = 1'b0;
        wb_stb_o   = 1'b0;
        wb_we_o    = 1'b0;
        wb_adr_o   = 32'd0;
        wb_dat_o   = 32'd0;
        wb_cti_o   = 3'b000;
        case (state)
            IDLE: begin
                if (!q_empty || addr_wr) begin
                    q_pop   = 1'b1;
                    state_n = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if ({1'b0, fifo_level} >= LVL_BURST) state_n = BURST;
            end
            BURST: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_we_o  = 1'b1;
                wb_adr_o = base + {10'd0, word_cnt, 2'b00};
                wb_dat_o = fifo_data;
                wb_cti_o = last_beat ? CTI_EOB : CTI_INCR;
                if (wb_err_i) begin
                    fifo_flush = 1'b1;
                    set_err    = 1'b1;
                    state_n    = IRQ;
                end else if (wb_ack_i) begin
                    fifo_rd = 1'b1;
                    if (last_beat) begin
                        if (word_cnt == LAST_WORD) begin
                            set_done = 1'b1;
                            state_n  = IRQ;
                        end else begin
                            state_n = WAIT_DATA;
                        end
                    end
                end
            end
            IRQ: begin
                irq = 1'b1;
                if (irq_cnt == LAST_IRQ) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            base      <= 32'd0;
            word_cnt  <= 20'd0;
            beat      <= '0;
            irq_cnt   <= '0;
            done_flag <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            state <= state_n;
            if (q_pop) begin
                base     <= q_head;
                word_cnt <= 20'd0;
                beat     <= '0;
            end else if (fifo_rd) begin
                word_cnt <= word_cnt + 20'd1;
                beat     <= last_beat ? '0 : beat + BEAT_W'(1);
            end
            irq_cnt   <= (state == IRQ) ? irq_cnt + IRQ_W'(1) : '0;
            done_flag <= set_done | (done_flag & ~irq_ack);
            err_flag  <= set_err | (err_flag & ~irq_ack);
        end
    end

endmodule

// File: tb/tb_video_frame_writer.sv
// Directed bench for video_frame_writer on a 16x4 frame with 4-word bursts:
// FIFO model, Wishbone slave with wait/error injection, beat log.
module tb_video_frame_writer;

    localparam int PW = 16;
    localparam int PH = 4;
    localparam int BL = 4;
    localparam int IC = 4;
    localparam int LW = 8;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          nRST;
    logic          addr_wr;
    logic [31:0]   addr_in;
    logic          irq_ack;
    logic [LW-1:0] fifo_level;
    logic [31:0]   fifo_data;
    logic          fifo_rd, fifo_flush, irq;
    logic [3:0]    status;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]    wb_sel_o;
    logic [31:0]   wb_adr_o, wb_dat_o;
    logic [2:0]    wb_cti_o;
    logic [1:0]    wb_bte_o;
    logic          wb_ack_i = 1'b0;
    logic          wb_err_i = 1'b0;

    video_frame_writer #(
        .P_WIDTH(PW), .P_HEIGHT(PH), .BURST_LEN(BL), .INT_CYCLES(IC), .LVL_W(LW)
    ) dut (
        .clk(clk), .nRST(nRST), .addr_wr(addr_wr), .addr_in(addr_in), .irq_ack(irq_ack),
        .fifo_level(fifo_level), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
        .fifo_flush(fifo_flush), .irq(irq), .status(status),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // FIFO model: head word is a running sequence number, popped on the edge after fifo_rd.
    int unsigned rd_n = 0;
    logic        pop_next = 1'b0;
    assign fifo_data = 32'hA500_0000 + rd_n;
    always @(posedge clk) if (pop_next) rd_n <= rd_n + 1;

    // Slave: answers each beat after 0 (or random 0..3) wait states; one chosen beat gets ERR.
    bit wait_mode = 1'b0;
    int err_beat = -1;
    int slave_beats = 0;
    int waits = 0;
    always begin
        @(posedge clk);
        #1;
        if (wb_stb_o) begin
            if (waits > 0) begin
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
                waits--;
            end else begin
                wb_err_i = (slave_beats == err_beat);
                wb_ack_i = !wb_err_i;
                slave_beats++;
                waits = wait_mode ? int'($urandom_range(0, 3)) : 0;
            end
        end else begin
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
        end
    end

    // Mid-cycle monitor: beat log (the RAM image), pop/flush counts, wait-state stability.
    logic [31:0] log_adr [512];
    logic [31:0] log_dat [512];
    logic [2:0]  log_cti [512];
    int beat_n = 0, rd_cnt = 0, flush_cnt = 0, stab_n = 0, stab_bad = 0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_adr = '0, prev_dat = '0;
    logic [2:0]  prev_cti = '0;
    always @(negedge clk) begin
        pop_next = fifo_rd;
        if (fifo_rd)    rd_cnt++;
        if (fifo_flush) flush_cnt++;
        if (wb_stb_o && prev_wait) begin
            stab_n++;
            if (wb_adr_o != prev_adr || wb_dat_o != prev_dat || wb_cti_o != prev_cti) stab_bad++;
        end
        prev_wait = wb_stb_o && !wb_ack_i && !wb_err_i;
        prev_adr  = wb_adr_o;
        prev_dat  = wb_dat_o;
        prev_cti  = wb_cti_o;
        if (wb_stb_o && wb_ack_i && !wb_err_i && beat_n < 512) begin
            log_adr[beat_n] = wb_adr_o;
            log_dat[beat_n] = wb_dat_o;
            log_cti[beat_n] = wb_cti_o;
            beat_n++;
        end
    end

    typedef struct packed {
        logic [31:0] adr;
        logic [2:0]  cti;
        logic [31:0] dat;
    } beat_t;
    beat_t exp_tbl [FW];

    task automatic build_tbl(input logic [31:0] base, input int unsigned r0);
        for (int i = 0; i < FW; i++) begin
            exp_tbl[i].adr = base + 32'(4 * i);
            exp_tbl[i].cti = ((i % BL) == BL - 1) ? 3'b111 : 3'b010;
            exp_tbl[i].dat = 32'hA500_0000 + r0 + 32'(i);
        end
    endtask

    task automatic check_frame(input string name, input int b0);
        for (int i = 0; i < FW; i++) begin
            check($sformatf("%s adr[%0d]", name, i), log_adr[b0 + i], exp_tbl[i].adr);
            check($sformatf("%s cti[%0d]", name, i), 32'(log_cti[b0 + i]), 32'(exp_tbl[i].cti));
            check($sformatf("%s dat[%0d]", name, i), log_dat[b0 + i], exp_tbl[i].dat);
        end
    endtask

    task automatic push_addr(input logic [31:0] a);
        addr_wr = 1'b1;
        addr_in = a;
        @(negedge clk);
        addr_wr = 1'b0;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
    endtask

    task automatic wait_irq_high(input string name);
        int n = 0;
        while (!irq && n < 400) begin @(negedge clk); n++; end
        if (!irq) begin
            checks++; errors++;
            $display("FAIL %s: irq never rose within 400 cycles", name);
        end
    endtask

    task automatic wait_irq_low(input string name, output int len);
        len = 0;
        while (irq && len < 50) begin @(negedge clk); len++; end
        if (irq) begin
            checks++; errors++;
            $display("FAIL %s: irq still high after 50 cycles", name);
        end
    endtask

    task automatic wait_stb(input string name);
        int n = 0;
        while (!wb_stb_o && n < 100) begin @(negedge clk); n++; end
        if (!wb_stb_o) begin
            checks++; errors++;
            $display("FAIL %s: no strobe within 100 cycles", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r0;
        int b0, b1, rc0, fl0, sb0, st0, len, n;

        nRST = 1'b0; addr_wr = 1'b0; addr_in = '0; irq_ack = 1'b0; fifo_level = 8'd32;
        #12;
        check("rst status", 32'(status), 0);
        check("rst cyc", 32'(wb_cyc_o), 0);
        check("rst stb", 32'(wb_stb_o), 0);
        check("rst we", 32'(wb_we_o), 0);
        check("rst adr", wb_adr_o, 0);
        check("rst dat", wb_dat_o, 0);
        check("rst cti", 32'(wb_cti_o), 0);
        check("rst bte", 32'(wb_bte_o), 0);
        check("rst sel", 32'(wb_sel_o), 32'hF);
        check("rst fifo_rd", 32'(fifo_rd), 0);
        check("rst flush", 32'(fifo_flush), 0);
        check("rst irq", 32'(irq), 0);
        @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);

        // Full frame, ACK always high; low address bits must be ignored.
        r0 = rd_n; b0 = beat_n; rc0 = rd_cnt;
        push_addr(32'h0000_1003);
        check("t1 wait_data stb", 32'(wb_stb_o), 0);
        check("t1 wait_data busy", 32'(status[0]), 1);
        @(negedge clk);
        check("t1 first stb", 32'(wb_stb_o), 1);
        check("t1 first adr", wb_adr_o, 32'h1000);
        repeat (4) @(negedge clk);
        check("t1 burst gap cyc", 32'(wb_cyc_o), 0);
        @(negedge clk);
        check("t1 burst2 adr", wb_adr_o, 32'h1010);
        wait_irq_high("t1");
        check("t1 irq status", 32'(status), 32'b0011);
        wait_irq_low("t1", len);
        check("t1 irq length", 32'(len), IC);
        check("t1 idle status", 32'(status), 32'b0010);
        build_tbl(32'h1000, r0);
        check_frame("t1", b0);
        check("t1 beats", 32'(beat_n - b0), FW);
        check("t1 fifo_rd count", 32'(rd_cnt - rc0), FW);
        pulse_ack();
        check("t1 status after ack", 32'(status), 0);

        // FIFO level one short of a burst holds off the bus.
        fifo_level = 8'd3;
        push_addr(32'h0000_2000);
        repeat (5) @(negedge clk);
        check("t2 low level stb", 32'(wb_stb_o), 0);
        check("t2 low level busy", 32'(status[0]), 1);
        fifo_level = 8'd4;
        @(negedge clk);
        check("t2 level 4 stb", 32'(wb_stb_o), 1);
        check("t2 level 4 adr", wb_adr_o, 32'h2000);
        fifo_level = 8'd32;
        wait_irq_high("t2");
        wait_irq_low("t2", len);
        pulse_ack();

        // ERR on the 2nd beat of burst 3, next queued frame restarts at word 0.
        fl0 = flush_cnt; rc0 = rd_cnt;
        err_beat = slave_beats + 9;
        push_addr(32'h0000_4000);
        push_addr(32'h0000_5000);
        n = 0;
        while (!(wb_stb_o && wb_err_i) && n < 200) begin @(negedge clk); n++; end
        check("t3 err seen", 32'(wb_stb_o && wb_err_i), 1);
        check("t3 flush on err", 32'(fifo_flush), 1);
        check("t3 no pop on err", 32'(fifo_rd), 0);
        check("t3 err adr", wb_adr_o, 32'h4024);
        b1 = beat_n;
        @(negedge clk);
        err_beat = -1;
        check("t3 cyc dropped", 32'(wb_cyc_o), 0);
        check("t3 irq", 32'(irq), 1);
        check("t3 irq status", 32'(status), 32'b0101);
        check("t3 pops before err", 32'(rd_cnt - rc0), 9);
        wait_irq_low("t3 err", len);
        wait_irq_high("t3 next");
        wait_irq_low("t3 next", len);
        check("t3 next frame adr", log_adr[b1], 32'h5000);
        check("t3 next frame beats", 32'(beat_n - b1), FW);
        check("t3 flush pulses", 32'(flush_cnt - fl0), 1);
        check("t3 idle status", 32'(status), 32'b0110);
        pulse_ack();
        check("t3 status after ack", 32'(status), 0);

        // Queue overflow: fourth address while two are queued and one is active.
        b0 = beat_n;
        push_addr(32'h0000_6000);
        push_addr(32'h0000_7000);
        push_addr(32'h0000_8000);
        push_addr(32'h0000_9000);
        check("t4 ovf set", 32'(status[3]), 1);
        for (int k = 0; k < 3; k++) begin
            wait_irq_high("t4");
            wait_irq_low("t4", len);
        end
        repeat (10) @(negedge clk);
        check("t4 frame0 adr", log_adr[b0], 32'h6000);
        check("t4 frame1 adr", log_adr[b0 + FW], 32'h7000);
        check("t4 frame2 adr", log_adr[b0 + 2 * FW], 32'h8000);
        check("t4 no 4th frame", 32'(beat_n - b0), 3 * FW);
        check("t4 idle status", 32'(status), 32'b1010);
        pulse_ack();
        check("t4 status after ack", 32'(status), 0);

        // Random wait states: outputs hold while waiting, RAM matches the FIFO sequence.
        wait_mode = 1'b1;
        r0 = rd_n; b0 = beat_n; st0 = stab_n; sb0 = stab_bad;
        push_addr(32'h0000_A000);
        wait_irq_high("t5");
        wait_mode = 1'b0;
        build_tbl(32'h0000_A000, r0);
        check_frame("t5", b0);
        check("t5 stable while waiting", 32'(stab_bad - sb0), 0);
        check("t5 waits occurred", 32'(stab_n > st0), 1);
        wait_irq_low("t5", len);
        pulse_ack();

        // Asynchronous reset in the middle of a burst, with a second address queued.
        push_addr(32'h0000_B000);
        push_addr(32'h0000_C000);
        wait_stb("t6");
        @(negedge clk);
        #2;
        nRST = 1'b0;
        #1;
        check("t6 async cyc", 32'(wb_cyc_o), 0);
        check("t6 async stb", 32'(wb_stb_o), 0);
        check("t6 async fifo_rd", 32'(fifo_rd), 0);
        check("t6 async adr", wb_adr_o, 0);
        check("t6 async dat", wb_dat_o, 0);
        check("t6 async cti", 32'(wb_cti_o), 0);
        check("t6 async status", 32'(status), 0);
        @(negedge clk);
        nRST = 1'b1;
        repeat (3) @(negedge clk);
        check("t6 idle after reset", 32'(status), 0);
        check("t6 queue empty", 32'(wb_cyc_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
